// File: rtl/loop_gain_pkg.sv
// Shared types, default widths and the quarter-sine table generator for the loop-gain receiver.
package loop_gain_pkg;

    localparam int unsigned DefDw   = 16;
    localparam int unsigned DefPhw  = 24;
    localparam int unsigned DefLw   = 10;
    localparam int unsigned DefCw   = 16;
    localparam int unsigned DefAccw = 48;
    localparam int unsigned DefPcw  = 16;

    typedef enum logic [2:0] {
        StIdle,
        StArm,
        StRun,
        StDrain,
        StDone
    } lg_state_e;

    // round(peak * sin(2*pi*idx / 2^lw)) for the first quadrant; Taylor series keeps it
    // independent of simulator math libraries.
    function automatic int quarter_sine(input int idx, input int lw, input int cw);
        real x;
        real term;
        real acc;
        real peak;
        x    = 2.0 * 3.14159265358979323846 * real'(idx) / real'(1 << lw);
        peak = real'((1 << (cw - 1)) - 1);
        term = x;
        acc  = x;
        for (int k = 1; k <= 12; k++) begin
            term = -term * x * x / real'((2 * k) * (2 * k + 1));
            acc  = acc + term;
        end
        return $rtoi(acc * peak + 0.5);
    endfunction

endpackage

// File: rtl/loop_gain_detector_sincos_lut.sv
// Registered cos/sin reference generator built from a quarter-wave table and symmetry folding.
module sincos_lut
    import loop_gain_pkg::*;
#(
    parameter int unsigned LW = DefLw,
    parameter int unsigned CW = DefCw
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [LW-1:0]        addr,
    output logic signed [CW-1:0] cos_val,
    output logic signed [CW-1:0] sin_val
);

    localparam int unsigned QN = 1 << (LW - 2);
    localparam logic [LW-1:0] QOff = LW'(QN);
    localparam logic signed [CW-1:0] Peak = {1'b0, {(CW - 1) {1'b1}}};

    logic signed [CW-1:0] qtab [QN];

    for (genvar i = 0; i < QN; i++) begin : g_tab
        assign qtab[i] = CW'(quarter_sine(i, LW, CW));
    end

    // Quadrant bit 0 mirrors the index, quadrant bit 1 negates; sin(pi/2) is not in the table.
    function automatic logic signed [CW-1:0] fold(input logic [LW-1:0] a);
        logic [LW-3:0]        idx;
        logic [LW-3:0]        midx;
        logic signed [CW-1:0] mag;
        idx  = a[LW-3:0];
        midx = -idx;
        if (!a[LW-2]) begin
            mag = qtab[idx];
        end else if (idx == '0) begin
            mag = Peak;
        end else begin
            mag = qtab[midx];
        end
        return a[LW-1] ? -mag : mag;
    endfunction

    // One-cycle registered lookup; cos is sin advanced by a quarter cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cos_val <= '0;
            sin_val <= '0;
        end else begin
            sin_val <= fold(addr);
            cos_val <= fold(addr + QOff);
        end
    end

endmodule

// File: rtl/loop_gain_detector.sv
// Lock-in correlator: multiplies input/output node samples by cos/sin references over an
// integer number of reference periods and returns the four correlation sums.
module loop_gain_detector
    import loop_gain_pkg::*;
#(
    parameter int unsigned DW   = DefDw,
    parameter int unsigned PHW  = DefPhw,
    parameter int unsigned LW   = DefLw,
    parameter int unsigned CW   = DefCw,
    parameter int unsigned ACCW = DefAccw,
    parameter int unsigned PCW  = DefPcw
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [PHW-1:0]         ftw,
    input  logic [PCW-1:0]         n_periods,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic signed [DW-1:0]   s_in,
    input  logic signed [DW-1:0]   s_out,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    output logic signed [ACCW-1:0] res_ii,
    output logic signed [ACCW-1:0] res_qi,
    output logic signed [ACCW-1:0] res_io,
    output logic signed [ACCW-1:0] res_qo,
    output logic [31:0]            res_cnt
);

    localparam int unsigned PW = DW + CW;

    lg_state_e      state_q;
    logic [PHW-1:0] ftw_q;
    logic [PCW-1:0] nper_q;
    logic [1:0]     drain_cnt_q;

    logic [PHW-1:0] phase_q;
    logic [PCW-1:0] per_cnt_q;
    logic [PHW-1:0] phase_sum;
    logic           carry;
    logic           accept;
    logic           last_wrap;
    logic           arm;

    logic                 v1_q, v2_q, v3_q;
    logic signed [DW-1:0] s1_in_q, s1_out_q, s2_in_q, s2_out_q;
    logic [LW-1:0]        addr1_q;
    logic signed [CW-1:0] lut_cos, lut_sin;
    logic signed [PW-1:0] p_ii_q, p_qi_q, p_io_q, p_qo_q;

    // Acceptance, phase increment with carry, and detection of the final period wrap.
    always_comb begin
        accept             = s_valid && s_ready;
        arm                = (state_q == StArm);
        {carry, phase_sum} = {1'b0, phase_q} + {1'b0, ftw_q};
        last_wrap          = carry && (per_cnt_q == nper_q - PCW'(1));
    end

    // Measurement FSM with registered handshake and status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            s_ready     <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            ftw_q       <= '0;
            nper_q      <= '0;
            drain_cnt_q <= '0;
        end else begin
            done <= 1'b0;
            unique case (state_q)
                StIdle, StDone: begin
                    if (start) begin
                        state_q <= StArm;
                        busy    <= 1'b1;
                        err     <= 1'b0;
                        ftw_q   <= ftw;
                        nper_q  <= n_periods;
                    end
                end
                StArm: begin
                    if (ftw_q == '0 || nper_q == '0) begin
                        state_q <= StDone;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        err     <= 1'b1;
                    end else begin
                        state_q <= StRun;
                        s_ready <= 1'b1;
                    end
                end
                StRun: begin
                    if (accept && last_wrap) begin
                        state_q     <= StDrain;
                        s_ready     <= 1'b0;
                        drain_cnt_q <= '0;
                    end
                end
                StDrain: begin
                    // Three cycles lets the last sample clear S1..S3 and the accumulate stage.
                    if (drain_cnt_q == 2'd2) begin
                        state_q <= StDone;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end else begin
                        drain_cnt_q <= drain_cnt_q + 2'd1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Phase accumulator and period counter advance only on accepted samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q   <= '0;
            per_cnt_q <= '0;
        end else if (arm) begin
            phase_q   <= '0;
            per_cnt_q <= '0;
        end else if (accept) begin
            phase_q <= phase_sum;
            if (carry) begin
                per_cnt_q <= per_cnt_q + PCW'(1);
            end
        end
    end

    // S1: capture samples with the pre-increment phase address.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q     <= 1'b0;
            s1_in_q  <= '0;
            s1_out_q <= '0;
            addr1_q  <= '0;
        end else begin
            v1_q <= accept && !arm;
            if (accept) begin
                s1_in_q  <= s_in;
                s1_out_q <= s_out;
                addr1_q  <= phase_q[PHW-1 -: LW];
            end
        end
    end

    sincos_lut #(
        .LW (LW),
        .CW (CW)
    ) u_lut (
        .clk     (clk),
        .rst     (rst),
        .addr    (addr1_q),
        .cos_val (lut_cos),
        .sin_val (lut_sin)
    );

    // S2 aligns samples with the LUT output; S3 forms the four products.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2_q     <= 1'b0;
            v3_q     <= 1'b0;
            s2_in_q  <= '0;
            s2_out_q <= '0;
            p_ii_q   <= '0;
            p_qi_q   <= '0;
            p_io_q   <= '0;
            p_qo_q   <= '0;
        end else begin
            v2_q     <= v1_q && !arm;
            v3_q     <= v2_q && !arm;
            s2_in_q  <= s1_in_q;
            s2_out_q <= s1_out_q;
            p_ii_q   <= PW'(s2_in_q) * PW'(lut_cos);
            p_qi_q   <= PW'(s2_in_q) * PW'(lut_sin);
            p_io_q   <= PW'(s2_out_q) * PW'(lut_cos);
            p_qo_q   <= PW'(s2_out_q) * PW'(lut_sin);
        end
    end

    // Accumulate stage (modulo 2^ACCW) and saturating accepted-sample counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_ii  <= '0;
            res_qi  <= '0;
            res_io  <= '0;
            res_qo  <= '0;
            res_cnt <= '0;
        end else if (arm) begin
            res_ii  <= '0;
            res_qi  <= '0;
            res_io  <= '0;
            res_qo  <= '0;
            res_cnt <= '0;
        end else begin
            if (v3_q) begin
                res_ii <= res_ii + ACCW'(p_ii_q);
                res_qi <= res_qi + ACCW'(p_qi_q);
                res_io <= res_io + ACCW'(p_io_q);
                res_qo <= res_qo + ACCW'(p_qo_q);
            end
            if (accept && res_cnt != '1) begin
                res_cnt <= res_cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_loop_gain_detector.sv
// Self-checking bench for loop_gain_detector: directed scenarios, a boundary table and
// randomized runs against a floating-point lock-in model.
module tb_loop_gain_detector;

    localparam int PHW  = 24;
    localparam int PCW  = 16;
    localparam int LW   = 10;
    localparam real PI  = 3.14159265358979323846;

    logic                clk;
    logic                rst;
    logic                start;
    logic [PHW-1:0]      ftw;
    logic [PCW-1:0]      n_periods;
    logic                s_valid;
    logic                s_ready;
    logic signed [15:0]  s_in;
    logic signed [15:0]  s_out;
    logic                busy;
    logic                done;
    logic                err;
    logic signed [47:0]  res_ii, res_qi, res_io, res_qo;
    logic [31:0]         res_cnt;

    loop_gain_detector dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .ftw       (ftw),
        .n_periods (n_periods),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_in      (s_in),
        .s_out     (s_out),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .res_ii    (res_ii),
        .res_qi    (res_qi),
        .res_io    (res_io),
        .res_qo    (res_qo),
        .res_cnt   (res_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [PHW-1:0] f;
        logic [PCW-1:0] np;
        int             vpct;
        int             exp_cnt;
    } vec_t;

    int     n_tests = 0;
    int     n_fail  = 0;
    int     in_q[$];
    int     out_q[$];
    longint r_ii, r_qi, r_io, r_qo, r_cnt;
    longint s1_ii, s1_qi, s1_io, s1_qo, s1_cnt;
    longint e_ii, e_qi, e_io, e_qo;
    logic   r_err;

    task automatic check(input string name, input longint got, input longint exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    function automatic int rnd(input real v);
        return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
    endfunction

    function automatic longint labs(input longint v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic int ref_sin(input int a);
        return rnd(32767.0 * $sin(2.0 * PI * real'(a) / real'(1 << LW)));
    endfunction

    function automatic longint wrap48(input longint v);
        logic [47:0] t;
        t = v[47:0];
        return longint'(signed'(t));
    endfunction

    // Sample k is the last one included when k*ftw first reaches n*2^PHW.
    function automatic int exp_count(input logic [PHW-1:0] f, input logic [PCW-1:0] np);
        longint num;
        num = longint'(np) * (longint'(1) << PHW);
        return int'((num + longint'(f) - 1) / longint'(f));
    endfunction

    function automatic longint phase_of(input int j, input logic [PHW-1:0] f);
        return (longint'(j) * longint'(f)) % (longint'(1) << PHW);
    endfunction

    function automatic int wave(input int mode, input real th);
        case (mode)
            0: return 0;
            1: return rnd(1000.0 * $cos(th));
            2: return rnd(500.0 * $sin(th));
            default: return int'($urandom_range(0, 65535)) - 32768;
        endcase
    endfunction

    task automatic fill_samples(input int mi, input int mo, input logic [PHW-1:0] f,
                                input int n);
        real th;
        in_q.delete();
        out_q.delete();
        for (int j = 0; j < n; j++) begin
            th = 2.0 * PI * real'(phase_of(j, f)) / real'(longint'(1) << PHW);
            in_q.push_back(wave(mi, th));
            out_q.push_back(wave(mo, th));
        end
    endtask

    task automatic calc_expect(input logic [PHW-1:0] f);
        int a, c, s;
        e_ii = 0; e_qi = 0; e_io = 0; e_qo = 0;
        for (int j = 0; j < in_q.size(); j++) begin
            a = int'(phase_of(j, f) >> (PHW - LW));
            s = ref_sin(a);
            c = ref_sin((a + (1 << (LW - 2))) % (1 << LW));
            e_ii += longint'(in_q[j]) * c;
            e_qi += longint'(in_q[j]) * s;
            e_io += longint'(out_q[j]) * c;
            e_qo += longint'(out_q[j]) * s;
        end
        e_ii = wrap48(e_ii); e_qi = wrap48(e_qi);
        e_io = wrap48(e_io); e_qo = wrap48(e_qo);
    endtask

    // Start a measurement, stream the queued samples, and capture results at done.
    task automatic do_run(input logic [PHW-1:0] f, input logic [PCW-1:0] np, input int vpct,
                          input bit poke, input string tag);
        int acc, cyc, last_cyc, n;
        bit seen;
        n = in_q.size();
        acc = 0; cyc = 0; last_cyc = -100; seen = 1'b0;
        ftw = f; n_periods = np; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        while (!seen && cyc < 4000) begin
            if (done) begin
                seen = 1'b1;
            end else begin
                s_valid = 1'b0;
                if (s_ready && acc < n && int'($urandom_range(0, 99)) < vpct) begin
                    s_valid = 1'b1;
                    s_in = 16'(in_q[acc]);
                    s_out = 16'(out_q[acc]);
                    acc++;
                    last_cyc = cyc;
                end
                start = poke && ((busy && !s_ready) || acc == 5);
                @(posedge clk); #1;
                cyc++;
            end
        end
        s_valid = 1'b0;
        start = 1'b0;
        check({tag, "_done_seen"}, longint'(seen), 1);
        check({tag, "_accepted"}, acc, n);
        check({tag, "_latency"}, cyc - last_cyc, 4);
        r_ii = res_ii; r_qi = res_qi; r_io = res_io; r_qo = res_qo;
        r_cnt = res_cnt; r_err = err;
        check({tag, "_err"}, longint'(r_err), 0);
        @(posedge clk); #1;
        check({tag, "_done_pulse"}, longint'(done), 0);
        check({tag, "_hold_ii"}, res_ii, r_ii);
    endtask

    task automatic err_start(input logic [PHW-1:0] f, input logic [PCW-1:0] np,
                             input string tag);
        bit rdy;
        ftw = f; n_periods = np; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        rdy = s_ready;
        check({tag, "_arm_busy"}, longint'(busy), 1);
        check({tag, "_arm_done"}, longint'(done), 0);
        @(posedge clk); #1;
        rdy |= s_ready;
        check({tag, "_done"}, longint'(done), 1);
        check({tag, "_err"}, longint'(err), 1);
        check({tag, "_busy"}, longint'(busy), 0);
        check({tag, "_res_zero"},
              longint'(res_ii != 0 || res_qi != 0 || res_io != 0 || res_qo != 0), 0);
        check({tag, "_cnt_zero"}, res_cnt, 0);
        repeat (3) begin
            @(posedge clk); #1;
            rdy |= s_ready;
        end
        check({tag, "_done_low"}, longint'(done), 0);
        check({tag, "_err_held"}, longint'(err), 1);
        check({tag, "_ready_never"}, longint'(rdy), 0);
    endtask

    task automatic check_results(input string tag);
        check({tag, "_ii"}, r_ii, e_ii);
        check({tag, "_qi"}, r_qi, e_qi);
        check({tag, "_io"}, r_io, e_io);
        check({tag, "_qo"}, r_qo, e_qo);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    vec_t tbl[6];

    initial begin
        int acc, guard, dones;
        logic [PHW-1:0] rf;
        logic [PCW-1:0] rn;
        int rv;

        tbl[0] = '{f: 24'h100000, np: 16'd4, vpct: 100, exp_cnt: 64};
        tbl[1] = '{f: 24'h100000, np: 16'd1, vpct: 100, exp_cnt: 16};
        tbl[2] = '{f: 24'h300000, np: 16'd1, vpct: 100, exp_cnt: 6};
        tbl[3] = '{f: 24'h300000, np: 16'd3, vpct: 70,  exp_cnt: 16};
        tbl[4] = '{f: 24'hFFFFFF, np: 16'd2, vpct: 100, exp_cnt: 3};
        tbl[5] = '{f: 24'h800001, np: 16'd2, vpct: 60,  exp_cnt: 4};

        rst = 1'b1; start = 1'b0; ftw = '0; n_periods = '0;
        s_valid = 1'b0; s_in = '0; s_out = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs",
              longint'({s_ready, busy, done, err} != 4'b0 || res_ii != 0 || res_qi != 0 ||
                       res_io != 0 || res_qo != 0 || res_cnt != 0), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Cosine on s_in.
        fill_samples(1, 0, 24'h100000, 64);
        calc_expect(24'h100000);
        do_run(24'h100000, 16'd4, 100, 1'b0, "s1");
        check("s1_cnt", r_cnt, 64);
        check_results("s1");
        check("s1_ii_approx", longint'(labs(r_ii - 64'd1048544000) <= 64'd2097088), 1);
        check("s1_qi_small", longint'(labs(r_qi) < 64'd2097088), 1);
        s1_ii = r_ii; s1_qi = r_qi; s1_io = r_io; s1_qo = r_qo; s1_cnt = r_cnt;

        // Sine on s_out.
        fill_samples(0, 2, 24'h100000, 64);
        calc_expect(24'h100000);
        do_run(24'h100000, 16'd4, 100, 1'b0, "s2");
        check_results("s2");
        check("s2_qo_approx", longint'(labs(r_qo - 64'd524272000) <= 64'd1048544), 1);
        check("s2_io_small", longint'(labs(r_io) < 64'd1048544), 1);

        // Backpressure must not change results.
        fill_samples(1, 0, 24'h100000, 64);
        do_run(24'h100000, 16'd4, 50, 1'b0, "s3");
        check("s3_cnt", r_cnt, s1_cnt);
        check("s3_ii", r_ii, s1_ii);
        check("s3_qi", r_qi, s1_qi);
        check("s3_io", r_io, s1_io);
        check("s3_qo", r_qo, s1_qo);

        // Invalid configurations.
        err_start(24'h0, 16'd4, "s4_ftw0");
        err_start(24'h100000, 16'd0, "s4_np0");

        // Starts during ARM/RUN/DRAIN are ignored; also clears err from the previous run.
        fill_samples(1, 0, 24'h100000, 64);
        do_run(24'h100000, 16'd4, 100, 1'b1, "s6");
        check("s6_cnt", r_cnt, s1_cnt);
        check("s6_ii", r_ii, s1_ii);
        check("s6_qi", r_qi, s1_qi);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("s6_rearm_busy", longint'(busy), 1);
        @(posedge clk); #1;
        check("s6_rearm_clear_ii", res_ii, 0);
        check("s6_rearm_clear_cnt", res_cnt, 0);
        check("s6_rearm_ready", longint'(s_ready), 1);
        pulse_reset();

        // Reset mid-RUN after 20 accepted samples.
        fill_samples(1, 0, 24'h100000, 64);
        ftw = 24'h100000; n_periods = 16'd4; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        acc = 0; guard = 0;
        while (acc < 20 && guard < 200) begin
            s_valid = 1'b0;
            if (s_ready) begin
                s_valid = 1'b1; s_in = 16'(in_q[acc]); s_out = 16'(out_q[acc]); acc++;
            end
            @(posedge clk); #1;
            guard++;
        end
        check("s5_fed20", acc, 20);
        s_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("s5_rst_outputs",
              longint'({s_ready, busy, done, err} != 4'b0 || res_ii != 0 || res_qi != 0 ||
                       res_io != 0 || res_qo != 0 || res_cnt != 0), 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        dones = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (done) dones++;
        end
        check("s5_no_done", dones, 0);
        check("s5_idle_cnt", res_cnt, 0);
        check("s5_idle_busy", longint'(busy), 0);
        do_run(24'h100000, 16'd4, 100, 1'b0, "s5r");
        check("s5r_cnt", r_cnt, s1_cnt);
        check("s5r_ii", r_ii, s1_ii);
        check("s5r_qo", r_qo, s1_qo);

        // Boundary table: period-wrap counting with random samples.
        for (int i = 0; i < 6; i++) begin
            fill_samples(3, 3, tbl[i].f, exp_count(tbl[i].f, tbl[i].np));
            calc_expect(tbl[i].f);
            do_run(tbl[i].f, tbl[i].np, tbl[i].vpct, 1'b0, $sformatf("tbl%0d", i));
            check($sformatf("tbl%0d_cnt", i), r_cnt, tbl[i].exp_cnt);
            check_results($sformatf("tbl%0d", i));
        end

        // Randomized configurations.
        for (int i = 0; i < 6; i++) begin
            rf = PHW'($urandom_range(1 << 18, 1 << 22));
            rn = PCW'($urandom_range(1, 3));
            rv = int'($urandom_range(30, 100));
            fill_samples(3, 3, rf, exp_count(rf, rn));
            calc_expect(rf);
            do_run(rf, rn, rv, 1'b0, $sformatf("rnd%0d", i));
            check($sformatf("rnd%0d_cnt", i), r_cnt, exp_count(rf, rn));
            check_results($sformatf("rnd%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
